// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port data memory (port 0 CPU, port 1 debug/DMA).
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module ram_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata0_q, rdata1_q;
  logic        rvalid0_q, rvalid1_q;
  logic        tie_pick1;

`ifdef RAM_ARB_RR_EN
  // Last-served port; starts at 1 so port 0 wins the first tie after reset.
  logic last_q, last_d;

  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == SERVE0)      last_d = 1'b0;
    else if (state_q == SERVE1) last_d = 1'b1;
  end

  assign tie_pick1 = ~last_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The port being served is ignored, so the other port always gets the next slot.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = tie_pick1 ? SERVE1 : SERVE0;
        else if (req0)     state_d = SERVE0;
        else if (req1)     state_d = SERVE1;
        else               state_d = IDLE;
      end
      SERVE0:  state_d = req1 ? SERVE1 : IDLE;
      SERVE1:  state_d = req0 ? SERVE0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_a  = 32'd0;
    mem_wd = 32'd0;
    mem_we = 1'b0;
    case (state_q)
      SERVE0: begin
        gnt0   = 1'b1;
        mem_a  = 32'(addr0);
        mem_wd = wdata0;
        mem_we = we0;
      end
      SERVE1: begin
        gnt1   = 1'b1;
        mem_a  = 32'(addr1);
        mem_wd = wdata1;
        mem_we = we1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Reset wins over a load in flight: the access happens but its result is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= (state_q == SERVE0) && !we0;
      rvalid1_q <= (state_q == SERVE1) && !we1;
      if ((state_q == SERVE0) && !we0) rdata0_q <= mem_rd;
      if ((state_q == SERVE1) && !we1) rdata1_q <= mem_rd;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_ram_arbiter;

  typedef struct {
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [9:0]  addr_v [2];
  logic [31:0] wd_v   [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];

  txn_t        txq0[$], txq1[$];
  int          glog[$];
  int          checks = 0;
  int          errors = 0;

  // Reference-model state: who is granted this cycle, last port served, expected read results.
  int          exp_g;
  int          last_srv;
  logic [31:0] exp_rd [2];
  logic        exp_rv [2];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .req1(req_v[1]),
    .we0(we_v[0]), .we1(we_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wd_v[0]), .wdata1(wd_v[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd), .busy(busy)
  );

  // Memory the arbiter fronts: combinational read, write at the clock edge.
  assign mem_rd = env_mem[mem_a[9:0]];
  always @(posedge clk) if (mem_we) env_mem[mem_a[9:0]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int gl);
    txn_t t;
    for (int p = 0; p < 2; p++) begin
      if (!req_v[p] || gl == p) begin
        if ((p == 0 && txq0.size() > 0) || (p == 1 && txq1.size() > 0)) begin
          t = (p == 0) ? txq0.pop_front() : txq1.pop_front();
          req_v[p] = 1'b1; we_v[p] = t.we; addr_v[p] = t.a; wd_v[p] = t.d;
        end else begin
          req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wd_v[p] = '0;
        end
      end
    end
  endtask

  // One clock cycle: inputs already applied; check outputs, advance the model, then drive next inputs.
  task automatic cycle(input logic rst_n);
    int  gp, nxt, gl;
    bit  c0, c1;
    reset = rst_n;
    #1;
    gp = gnt0 ? 0 : (gnt1 ? 1 : -1);
    glog.push_back(gp);
    chk("gnt0", {31'd0, gnt0}, {31'd0, exp_g == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, exp_g == 1});
    chk("busy", {31'd0, busy}, {31'd0, exp_g != -1});
    chk("mem_we", {31'd0, mem_we}, (exp_g >= 0) ? {31'd0, we_v[exp_g]} : 32'd0);
    chk("mem_a", mem_a, (exp_g >= 0) ? {22'd0, addr_v[exp_g]} : 32'd0);
    chk("mem_wd", mem_wd, (exp_g >= 0) ? wd_v[exp_g] : 32'd0);
    chk("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rv[0]});
    chk("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rv[1]});
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);

    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (exp_g >= 0) begin
      if (we_v[exp_g]) ref_mem[addr_v[exp_g]] = wd_v[exp_g];
      else begin
        exp_rd[exp_g] = ref_mem[addr_v[exp_g]];
        exp_rv[exp_g] = 1'b1;
      end
      last_srv = exp_g;
    end
    c0 = req_v[0] && (exp_g != 0);
    c1 = req_v[1] && (exp_g != 1);
`ifdef RAM_ARB_RR_EN
    if (c0 && c1) nxt = (last_srv == 0) ? 1 : 0;
`else
    if (c0 && c1) nxt = 0;
`endif
    else if (c0)  nxt = 0;
    else if (c1)  nxt = 1;
    else          nxt = -1;
    if (!rst_n) begin
      exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
      exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
      last_srv  = 1;
      nxt       = -1;
    end
    gl    = exp_g;
    exp_g = nxt;
    @(posedge clk);
    #1;
    drive(gl);
  endtask

  task automatic cmp_glog(input string tag, input int e[$]);
    chk({tag, "_len"}, glog.size(), e.size());
    for (int i = 0; i < e.size() && i < glog.size(); i++)
      chk(tag, glog[i], e[i]);
  endtask

  task automatic push(input int p, input logic we, input logic [9:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.a = a; t.d = d;
    if (p == 0) txq0.push_back(t);
    else        txq1.push_back(t);
  endtask

  initial begin
    int e[$];
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = i * 32'h9E3779B9;
      ref_mem[i] = i * 32'h9E3779B9;
    end
    reset = 1'b0;
    req_v = '0; we_v = '0;
    addr_v[0] = '0; addr_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;
    @(posedge clk);
    #1;
    exp_g = -1; last_srv = 1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;

    // Reset state
    cycle(1'b0);

    // Simultaneous loads: first tie after reset goes to port 0, then port 1 with no idle gap
    push(0, 1'b0, 10'd1, 32'd0);
    push(1, 1'b0, 10'd2, 32'd0);
    cycle(1'b1);
    glog.delete();
    repeat (4) cycle(1'b1);
    e = '{-1, 0, 1, -1};
    cmp_glog("simul_loads", e);

    // Store then load on port 0
    push(0, 1'b1, 10'd5, 32'hDEADBEEF);
    push(0, 1'b0, 10'd5, 32'd0);
    cycle(1'b1);
    glog.delete();
    repeat (5) cycle(1'b1);
    e = '{-1, 0, -1, 0, -1};
    cmp_glog("store_load", e);
    chk("store_load_rdata", rdata0, 32'hDEADBEEF);

    // Continuous requests on both ports: strict alternation
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 10'(i + 10), 32'd0);
      push(1, 1'b0, 10'(i + 20), 32'd0);
    end
    cycle(1'b1);
    glog.delete();
    repeat (8) cycle(1'b1);
`ifdef RAM_ARB_RR_EN
    e = '{-1, 1, 0, 1, 0, 1, 0, -1};
`else
    e = '{-1, 0, 1, 0, 1, 0, 1, -1};
`endif
    cmp_glog("continuous", e);

    // Same-port back-to-back loads on port 1
    push(1, 1'b0, 10'd7, 32'd0);
    push(1, 1'b0, 10'd8, 32'd0);
    cycle(1'b1);
    glog.delete();
    repeat (5) cycle(1'b1);
    e = '{-1, 1, -1, 1, -1};
    cmp_glog("b2b_port1", e);
    chk("b2b_rdata1", rdata1, 32'd8 * 32'h9E3779B9);

    // Reset asserted in the SERVE0 cycle of a load
    push(0, 1'b0, 10'd3, 32'd0);
    cycle(1'b1);
    glog.delete();
    cycle(1'b1);
    cycle(1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    cycle(1'b1);
    e = '{-1, 0, -1};
    cmp_glog("reset_mid_load", e);

    // Memory survives reset
    push(1, 1'b0, 10'd5, 32'd0);
    cycle(1'b1);
    repeat (3) cycle(1'b1);
    chk("mem_after_reset", rdata1, 32'hDEADBEEF);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if (txq0.size() == 0 && $urandom_range(0, 2) == 0)
        push(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      if (txq1.size() == 0 && $urandom_range(0, 2) == 0)
        push(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end
    repeat (8) cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
